text_renderer_attr: RTL
=======================

Name: text_renderer_attr

Overview:
Parametrised text-mode pixel pipeline that replaces the fixed monochrome 8x16 text path. Consumes pixel coordinates and raw sync/enable from the hsync/vsync timing counters and owns an internal dual-port character+attribute buffer. Drives an external 1-bit font ROM and outputs RGB565 with matching syncs. Adds per-cell 16-colour foreground and 8-colour background, blinking characters, a blinking underline cursor, and hardware row scroll.

Parameters:
FONT_W_LOG2, 3, log2 glyph width in pixels (8)
FONT_H_LOG2, 4, log2 glyph height in pixels (16)
COLS_LOG2, 6, log2 buffer columns (64)
ROWS_LOG2, 5, log2 buffer rows (32)
XY_W, 9, width of i_x/i_y
BLINK_FRAMES, 32, frames per blink half-period (>=1)

Ports:
i_clk  in  1  pixel clock (LCD_CLK)
i_rst  in  1  synchronous reset, active-high
i_x  in  XY_W  pixel column from hsync
i_y  in  XY_W  pixel row from vsync
i_hsync  in  1  undelayed hsync
i_vsync  in  1  undelayed vsync
i_de  in  1  undelayed data enable (hde & vde)
i_wr_en  in  1  buffer write strobe
i_wr_addr  in  ROWS_LOG2+COLS_LOG2  {row, col} write address
i_wr_char  in  8  character code
i_wr_attr  in  8  [3:0] fg index, [6:4] bg index, [7] blink
i_cursor_en  in  1  cursor enable
i_cursor_addr  in  ROWS_LOG2+COLS_LOG2  cursor cell {row, col}, buffer coordinates
i_scroll  in  ROWS_LOG2  buffer row shown at screen row 0
o_font_addr  out  8+FONT_H_LOG2+FONT_W_LOG2  {char, glyph row, glyph col}
i_font_px  in  1  font pixel, valid one cycle after o_font_addr
o_r  out  5  red
o_g  out  6  green
o_b  out  5  blue
o_hsync  out  1  hsync aligned to pixels
o_vsync  out  1  vsync aligned to pixels
o_de  out  1  data enable aligned to pixels

Behaviour:
- One clock i_clk; reset synchronous, active-high. Reset clears all pipeline regs: o_r/o_g/o_b=0, o_hsync=o_vsync=o_de=0, o_font_addr=0, frame counter=0, blink phase=1 (visible). Buffer RAM contents are not reset.
- Pipeline, fixed latency 3 cycles inputs -> o_*:
  - S0 (cycle 0): col = i_x >> FONT_W_LOG2 truncated to COLS_LOG2; row = ((i_y >> FONT_H_LOG2) + i_scroll) mod 2^ROWS_LOG2; RAM read of {row,col} issued.
  - S1 (cycle 1): char/attr registered from RAM; glyph x/y (low bits of i_x/i_y), cursor-hit and sync/de delayed 1. o_font_addr driven combinationally from S1 regs.
  - S2 (cycle 2): i_font_px valid; attr, cursor-hit, glyph row, sync/de delayed again.
  - S3 (cycle 3): registered colour select -> o_r/o_g/o_b; syncs/de delayed to total 3.
- Colour: fg_on = i_font_px & ~(attr[7] & ~phase); cursor_px = cursor_hit & phase & (glyph row >= 2^FONT_H_LOG2-2); pixel = (fg_on | cursor_px) ? PAL16[attr[3:0]] : PAL16[{1'b0,attr[6:4]}]. When delayed de=0, RGB forced 0.
- cursor_hit = i_cursor_en & ({row,col} == i_cursor_addr), sampled in S0 with scrolled row.
- Coordinates beyond buffer extent wrap modulo columns/rows; no error.
- Write port: single cycle, any time, independent of display. Same-address read/write in one cycle: read returns old data (read-first); new data visible next access.
- Blink: rising edge of i_vsync (edge detect on registered copy, in i_clk domain) increments frame counter; at BLINK_FRAMES-1 counter -> 0 and phase toggles. Phase changes only at a frame start, never mid-frame.
- i_scroll and i_cursor_* sampled every pixel; caller changes them during vblank for tear-free update.
- Reset mid-frame: outputs return to 0 next cycle; valid pixels resume 3 cycles after deassert.

Decomposition:
- Package text_pkg: PAL16 RGB565 constant array (CGA order: 0 black, 7 light grey 0xC618, 15 white 0xFFFF, 4 red 0xA800, ...), attr field bit positions, pipeline latency constant TEXT_LAT=3.
- Sub-module charbuf_attr_dp: simple dual-port RAM, 16-bit word {attr,char}, depth 2^(ROWS_LOG2+COLS_LOG2), write port A, registered read port B, read-first.

Test Plan:
- Write cell (0,0) char 0x41 attr 0x1F, model font 'A' -> pixels of cell 0 show 0xFFFF where glyph set, bg index 1 (blue 0x0015) elsewhere; first output 3 cycles after x=0,y=0.
- Pulse i_hsync/i_vsync/i_de at arbitrary cycles -> o_* reproduce exact pattern delayed 3 cycles; RGB=0 whenever o_de=0.
- Write row 5 col 0 char 0x42, set i_scroll=5 -> screen row 0 shows 0x42; scroll=31 with ROWS_LOG2=5 -> screen row 1 shows buffer row 0 (wrap).
- attr 0x87, BLINK_FRAMES=2 -> glyph visible frames 0-1, background only frames 2-3, visible 4-5; toggles only at vsync rising edge.
- Cursor at {2,3}, enabled, space char attr 0x07 -> glyph rows 14,15 of that cell light grey during phase=1, background during phase=0; i_cursor_en=0 -> never drawn.
- Write same address being read in same cycle -> old value output for that pixel, new value on next frame; assert i_rst mid-line -> all outputs 0 next cycle, frame counter 0, phase 1.

Source files
------------

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants for the attribute text renderer
package text_pkg;

  // Cycles from i_x/i_y/syncs to o_* outputs
  localparam int TEXT_LAT = 3;

  // Attribute byte layout
  localparam int ATTR_FG_LSB    = 0;
  localparam int ATTR_BG_LSB    = 4;
  localparam int ATTR_BLINK_BIT = 7;

  // CGA 16-colour palette in RGB565
  localparam logic [15:0] PAL16 [16] = '{
    16'h0000, 16'h0015, 16'h0540, 16'h0555,
    16'hA800, 16'hA815, 16'hAAA0, 16'hC618,
    16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
    16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
  };

endpackage

// File: rtl/charbuf_attr_dp.sv
// rtl/charbuf_attr_dp.sv - simple dual-port {attr,char} buffer, read-first
module charbuf_attr_dp #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  // Read sees the array before this cycle's write lands, giving read-first
  always_comb begin
    rd_data_d = mem[i_rd_addr];
  end

  // Write port; contents are deliberately not cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read data doubles as the renderer's S1 char/attr stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/text_renderer_attr.sv
// rtl/text_renderer_attr.sv - text-mode pixel pipeline with colour attributes, blink, cursor, scroll
module text_renderer_attr
  import text_pkg::*;
#(
  parameter int FONT_W_LOG2  = 3,
  parameter int FONT_H_LOG2  = 4,
  parameter int COLS_LOG2    = 6,
  parameter int ROWS_LOG2    = 5,
  parameter int XY_W         = 9,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [XY_W-1:0]                       i_x,
  input  logic [XY_W-1:0]                       i_y,
  input  logic                                  i_hsync,
  input  logic                                  i_vsync,
  input  logic                                  i_de,
  input  logic                                  i_wr_en,
  input  logic [ROWS_LOG2+COLS_LOG2-1:0]        i_wr_addr,
  input  logic [7:0]                            i_wr_char,
  input  logic [7:0]                            i_wr_attr,
  input  logic                                  i_cursor_en,
  input  logic [ROWS_LOG2+COLS_LOG2-1:0]        i_cursor_addr,
  input  logic [ROWS_LOG2-1:0]                  i_scroll,
  output logic [8+FONT_H_LOG2+FONT_W_LOG2-1:0]  o_font_addr,
  input  logic                                  i_font_px,
  output logic [4:0]                            o_r,
  output logic [5:0]                            o_g,
  output logic [4:0]                            o_b,
  output logic                                  o_hsync,
  output logic                                  o_vsync,
  output logic                                  o_de
);

  localparam int AW      = ROWS_LOG2 + COLS_LOG2;
  localparam int SYNC_W  = 3 * TEXT_LAT;
  localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CUR_ROW = (1 << FONT_H_LOG2) - 2;

  // S0 address/cursor signals
  logic [COLS_LOG2-1:0] s0_col;
  logic [ROWS_LOG2-1:0] s0_row;
  logic [AW-1:0]        s0_addr;
  logic                 s0_hit;
  logic [15:0]          s1_word;

  // Pipeline and blink state
  logic [FONT_W_LOG2-1:0] gx1_d, gx1_q;
  logic [FONT_H_LOG2-1:0] gy1_d, gy1_q, gy2_d, gy2_q;
  logic                   hit1_d, hit1_q, hit2_d, hit2_q;
  logic [7:0]             attr2_d, attr2_q;
  logic [15:0]            rgb_d, rgb_q;
  logic [SYNC_W-1:0]      sync_pipe_d, sync_pipe_q;
  logic                   vs_d, vs_q;
  logic [CNT_W-1:0]       frame_cnt_d, frame_cnt_q;
  logic                   phase_d, phase_q;

  // S2 colour terms
  logic                   de2;
  logic                   fg_on;
  logic                   cursor_px;
  logic [3:0]             fg_idx, bg_idx;

  charbuf_attr_dp #(
    .AW (AW),
    .DW (16)
  ) u_charbuf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data ({i_wr_attr, i_wr_char}),
    .i_rd_addr (s0_addr),
    .o_rd_data (s1_word)
  );

  assign o_font_addr = {s1_word[7:0], gy1_q, gx1_q};

  // Next-state for every pipeline stage plus the vsync-driven blink counter
  always_comb begin
    s0_col  = i_x[FONT_W_LOG2 +: COLS_LOG2];
    s0_row  = i_y[FONT_H_LOG2 +: ROWS_LOG2] + i_scroll;
    s0_addr = {s0_row, s0_col};
    s0_hit  = i_cursor_en && (s0_addr == i_cursor_addr);

    gx1_d  = i_x[FONT_W_LOG2-1:0];
    gy1_d  = i_y[FONT_H_LOG2-1:0];
    hit1_d = s0_hit;

    attr2_d = s1_word[15:8];
    hit2_d  = hit1_q;
    gy2_d   = gy1_q;

    de2       = sync_pipe_q[3];
    fg_on     = i_font_px & ~(attr2_q[ATTR_BLINK_BIT] & ~phase_q);
    cursor_px = hit2_q & phase_q & (gy2_q >= FONT_H_LOG2'(CUR_ROW));
    fg_idx    = attr2_q[ATTR_FG_LSB +: 4];
    bg_idx    = {1'b0, attr2_q[ATTR_BG_LSB +: 3]};
    rgb_d     = '0;
    if (de2) begin
      rgb_d = (fg_on | cursor_px) ? PAL16[fg_idx] : PAL16[bg_idx];
    end

    sync_pipe_d = {sync_pipe_q[SYNC_W-4:0], i_hsync, i_vsync, i_de};

    vs_d        = i_vsync;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (i_vsync && !vs_q) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Register all stages; reset clears the pipe and restarts blink as visible
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gx1_q       <= '0;
      gy1_q       <= '0;
      hit1_q      <= 1'b0;
      attr2_q     <= '0;
      hit2_q      <= 1'b0;
      gy2_q       <= '0;
      rgb_q       <= '0;
      sync_pipe_q <= '0;
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      gx1_q       <= gx1_d;
      gy1_q       <= gy1_d;
      hit1_q      <= hit1_d;
      attr2_q     <= attr2_d;
      hit2_q      <= hit2_d;
      gy2_q       <= gy2_d;
      rgb_q       <= rgb_d;
      sync_pipe_q <= sync_pipe_d;
      vs_q        <= vs_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign o_r     = rgb_q[15:11];
  assign o_g     = rgb_q[10:5];
  assign o_b     = rgb_q[4:0];
  assign o_hsync = sync_pipe_q[SYNC_W-1];
  assign o_vsync = sync_pipe_q[SYNC_W-2];
  assign o_de    = sync_pipe_q[SYNC_W-3];

endmodule
